multi_timer: RTL
================

// Module: multi_timer
// PURPOSE
//  Parametrised N-channel down-counting timer peripheral on the PicoRV32 native memory bus.
//  Each channel has its own prescaler, reload value, one-shot/periodic mode and sticky
//  expiry flag. The flags are ORed into one level IRQ line for the CPU.
//  Successor to the single-channel systick block.
//  Adds auto-reload, W1C status, byte-lane writes and multiple channels.
// PARAMETERS
//  N_CHANNELS     4   number of timer channels, 1..16
//  COUNTER_WIDTH  32  channel counter/reload width, 1..32
//  PRESC_WIDTH    16  prescaler width, 1..16
// PORTS
//  clk      in   1   single clock domain
//  reset    in   1   synchronous, active-high reset
//  select   in   1   bus access to this block; held by master until ready
//  wstrb    in   4   byte write strobes; 0 = read
//  addr     in   8   byte address: [7:4] channel index, [3:2] register, [1:0] ignored
//  data_i   in   32  write data
//  ready    out  1   one-cycle access-complete pulse
//  data_o   out  32  read data, valid while ready=1
//  irq      out  1   level interrupt, OR over channels of (EXPIRED & IE)
// BEHAVIOUR
//  Reset: all registers, prescaler counters, ready, data_o and irq go to 0. Reset wins over everything.
//  Bus handshake:
//   - ready <= select & ~ready; the access executes exactly once, in the cycle ready is driven to 1.
//   - Latency is 1 cycle from select to ready.
//   - data_o updates only on access; it holds its value otherwise.
//  Channel register map (base = ch*0x10):
//   - 0x0 CTRL
//       [0] EN
//       [1] MODE: 0 = one-shot, 1 = periodic
//       [2] IE
//       [3] LOAD, write-only, self-clearing, reads 0
//       [31:16] PRESC (low PRESC_WIDTH bits used)
//   - 0x4 RELOAD (RW)
//   - 0x8 COUNT (RW)
//   - 0xC STATUS
//       [0] RUNNING = EN, read-only
//       [1] EXPIRED, sticky, write-1-to-clear
//  Address/width rules:
//   - Channel index >= N_CHANNELS: reads return 0, writes are ignored.
//   - Unimplemented bits read 0. Bits above COUNTER_WIDTH and PRESC_WIDTH read 0 and ignore writes.
//   - Writes honour wstrb per byte lane.
//  Counting, per channel, when EN=1:
//   - pcnt increments each clk. When pcnt==PRESC: pcnt<=0 and a tick occurs.
//   - Tick with COUNT!=0: COUNT <= COUNT-1.
//   - Tick with COUNT==0: EXPIRED<=1.
//       Periodic: COUNT<=RELOAD.
//       One-shot: EN<=0, COUNT stays 0.
//   - Periodic expiry period = (RELOAD+1)*(PRESC+1) clocks.
//   - EN=0: pcnt and COUNT freeze. pcnt is not cleared.
//  LOAD=1 write: COUNT<=RELOAD and pcnt<=0 in the same cycle. Other CTRL fields from the same write also apply.
//  Writing COUNT: pcnt<=0.
//  irq is registered; it rises 1 cycle after EXPIRED&IE becomes true.
//  Simultaneous events:
//   - Bus write to COUNT/CTRL in a tick cycle: the bus write wins; that tick is discarded (no decrement, no expiry).
//   - W1C of EXPIRED in the same cycle a new expiry sets it: EXPIRED stays 1.
//   - Channels are fully independent; multiple channels may expire in the same cycle.
//  Reset mid-access: the pending access is dropped; ready stays 0.
// TESTING
//  1. Reset, read ch0 CTRL/COUNT/STATUS -> 0; ready pulses exactly 1 cycle per access while select held.
//  2. ch1 RELOAD=3, PRESC=1, CTRL=EN|periodic|IE|LOAD -> EXPIRED set every 8 clks, irq 1 cycle later;
//     W1C STATUS=0x2 -> irq drops next cycle.
//  3. ch0 one-shot COUNT=2, PRESC=0, EN -> expiry at 3rd tick, EN reads 0, COUNT stays 0.
//  4. Byte write wstrb=4'b0100 data 0x00AA0000 to CTRL -> only PRESC[7:0]=0xAA changes.
//  5. W1C in the exact cycle of a new expiry -> EXPIRED reads 1; COUNT write on a tick cycle -> written value kept.
//  6. Access addr 0x40 with N_CHANNELS=4 -> read 0, write no effect, ready still pulses.

Source files
------------

// File: rtl/multi_timer.sv
// N-channel down-counting timer on the PicoRV32 native memory bus.
// Each channel: prescaler, reload, one-shot/periodic mode, sticky W1C expiry flag.
module multi_timer #(
  parameter int unsigned N_CHANNELS    = 4,
  parameter int unsigned COUNTER_WIDTH = 32,
  parameter int unsigned PRESC_WIDTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        select,
  input  logic [3:0]  wstrb,
  input  logic [7:0]  addr,
  input  logic [31:0] data_i,
  output logic        ready,
  output logic [31:0] data_o,
  output logic        irq
);

  localparam int unsigned CW = COUNTER_WIDTH;
  localparam int unsigned PW = PRESC_WIDTH;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_RELOAD = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic [N_CHANNELS-1:0] en_q;
  logic [N_CHANNELS-1:0] mode_q;
  logic [N_CHANNELS-1:0] ie_q;
  logic [N_CHANNELS-1:0] expired_q;
  logic [PW-1:0]         presc_q  [N_CHANNELS];
  logic [PW-1:0]         pcnt_q   [N_CHANNELS];
  logic [CW-1:0]         reload_q [N_CHANNELS];
  logic [CW-1:0]         count_q  [N_CHANNELS];

  logic                  access;
  logic                  is_write;
  logic [3:0]            ch;
  logic [1:0]            rsel;
  logic [31:0]           wmask;
  logic [31:0]           rdata;
  logic [31:0]           merged;
  logic [N_CHANNELS-1:0] wr_ctrl;
  logic [N_CHANNELS-1:0] wr_reload;
  logic [N_CHANNELS-1:0] wr_count;
  logic [N_CHANNELS-1:0] w1c;
  logic [N_CHANNELS-1:0] tick_raw;
  logic [N_CHANNELS-1:0] tick;

  // The access executes in the single cycle in which ready is being raised
  assign access   = select & ~ready;
  assign is_write = |wstrb;
  assign ch       = addr[7:4];
  assign rsel     = addr[3:2];
  assign wmask    = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};

  // Byte-lane merge of write data over the current register view
  assign merged = (rdata & ~wmask) | (data_i & wmask);

  logic unused_ok;
  assign unused_ok = &{1'b0, addr[1:0], merged};

  // Read view of the addressed register; out-of-range channels read 0
  always_comb begin
    rdata = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      if (ch == 4'(i)) begin
        case (rsel)
          REG_CTRL:   rdata = {16'(presc_q[i]), 13'd0, ie_q[i], mode_q[i], en_q[i]};
          REG_RELOAD: rdata = 32'(reload_q[i]);
          REG_COUNT:  rdata = 32'(count_q[i]);
          default:    rdata = {30'd0, expired_q[i], en_q[i]};
        endcase
      end
    end
  end

  // Per-channel write decode and tick qualification (CTRL/COUNT writes swallow a tick)
  always_comb begin
    wr_ctrl   = '0;
    wr_reload = '0;
    wr_count  = '0;
    w1c       = '0;
    tick_raw  = '0;
    tick      = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      if (access && is_write && ch == 4'(i)) begin
        wr_ctrl[i]   = (rsel == REG_CTRL);
        wr_reload[i] = (rsel == REG_RELOAD);
        wr_count[i]  = (rsel == REG_COUNT);
        w1c[i]       = (rsel == REG_STATUS) && wstrb[0] && data_i[1];
      end
      tick_raw[i] = en_q[i] && (pcnt_q[i] == presc_q[i]);
      tick[i]     = tick_raw[i] && !wr_ctrl[i] && !wr_count[i];
    end
  end

  // Channel state: prescaler, counter, expiry; bus writes applied last so they win
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q      <= '0;
      mode_q    <= '0;
      ie_q      <= '0;
      expired_q <= '0;
      for (int i = 0; i < N_CHANNELS; i++) begin
        presc_q[i]  <= '0;
        pcnt_q[i]   <= '0;
        reload_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_CHANNELS; i++) begin
        if (tick_raw[i]) begin
          pcnt_q[i] <= '0;
        end else if (en_q[i]) begin
          pcnt_q[i] <= pcnt_q[i] + PW'(1);
        end
        if (tick[i]) begin
          if (count_q[i] != '0) begin
            count_q[i] <= count_q[i] - CW'(1);
          end else if (mode_q[i]) begin
            count_q[i] <= reload_q[i];
          end else begin
            en_q[i] <= 1'b0;
          end
        end
        expired_q[i] <= (expired_q[i] & ~w1c[i]) | (tick[i] & (count_q[i] == '0));
        if (wr_ctrl[i]) begin
          en_q[i]    <= merged[0];
          mode_q[i]  <= merged[1];
          ie_q[i]    <= merged[2];
          presc_q[i] <= merged[16 +: PW];
          if (merged[3]) begin
            count_q[i] <= reload_q[i];
            pcnt_q[i]  <= '0;
          end
        end
        if (wr_reload[i]) begin
          reload_q[i] <= merged[CW-1:0];
        end
        if (wr_count[i]) begin
          count_q[i] <= merged[CW-1:0];
          pcnt_q[i]  <= '0;
        end
      end
    end
  end

  // Bus handshake and read data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      ready  <= 1'b0;
      data_o <= '0;
    end else begin
      ready <= access;
      if (access && !is_write) begin
        data_o <= rdata;
      end
    end
  end

  // Registered level interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |(expired_q & ie_q);
    end
  end

endmodule
